// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: PCsrc encodings and FSM states.
package fetch_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_JMP = 2'b01;
  localparam logic [1:0] PCSRC_BR  = 2'b10;
  localparam logic [1:0] PCSRC_RET = 2'b11;

  // Squash counter width; KILL_CYCLES is limited to 1..3.
  localparam int KCNT_W = 2;

  typedef enum logic {
    RUN  = 1'b0,
    KILL = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/fetch_sequencer_return_addr_stack.sv
// Return-address stack: circular storage that overwrites the oldest entry when
// full; top of stack is read combinationally, errors are sticky until reset.
module return_addr_stack #(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] link_addr,
  output logic [ADDR_W-1:0] top,
  output logic              err
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  ptr_reg, ptr_next, ptr_top;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic [ADDR_W-1:0] entry_reg [RAS_DEPTH];
  logic              push_eff, full, empty;

  // A simultaneous pop wins; the push is dropped and flagged.
  assign push_eff = push & ~pop;
  assign full     = (cnt_reg == CNT_W'(RAS_DEPTH));
  assign empty    = (cnt_reg == '0);
  assign ptr_top  = ptr_reg - PTR_W'(1);

  always_comb begin
    ptr_next = ptr_reg;
    cnt_next = cnt_reg;
    if (pop) begin
      if (!empty) begin
        ptr_next = ptr_top;
        cnt_next = cnt_reg - CNT_W'(1);
      end
    end else if (push) begin
      ptr_next = ptr_reg + PTR_W'(1);
      if (!full) cnt_next = cnt_reg + CNT_W'(1);
    end
    err_next = err_reg | (pop & empty) | (push & pop) | (push_eff & full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
      err_reg <= err_next;
    end
  end

  for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        entry_reg[gi] <= '0;
      else if (push_eff && ptr_reg == PTR_W'(gi))
        entry_reg[gi] <= link_addr;
    end
  end

  assign top = empty ? '0 : entry_reg[ptr_top];
  assign err = err_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: request priority, post-redirect squash FSM and RAS.
// Optional FETCH_PERF_CNT_EN adds saturating stall/kill cycle counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int RAS_DEPTH   = 4,
  parameter int KILL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ext_stall,
  input  logic              load_use,
  input  logic              jump_req,
  input  logic              branch_taken,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [ADDR_W-1:0] link_addr,
  output logic [1:0]        PCsrc,
  output logic              stall,
  output logic              kill,
  output logic [ADDR_W-1:0] ReturnAddress,
  output logic              ras_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       kill_cnt
`endif
);

  fsm_state_e        state_reg, state_next;
  logic [KCNT_W-1:0] kcnt_reg, kcnt_next;
  logic              redirect, accept;

  assign redirect = ret_req | jump_req | call_req | branch_taken;
  assign accept   = (state_reg == RUN) & ~ext_stall & ~load_use & redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      kcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      kcnt_reg  <= kcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    kcnt_next  = kcnt_reg;
    case (state_reg)
      RUN: begin
        if (accept && KILL_CYCLES > 1) begin
          state_next = KILL;
          kcnt_next  = KCNT_W'(KILL_CYCLES - 1);
        end
      end
      KILL: begin
        // The squash window is frozen while memory is busy.
        if (!ext_stall) begin
          if (kcnt_reg <= KCNT_W'(1)) begin
            state_next = RUN;
            kcnt_next  = '0;
          end else begin
            kcnt_next = kcnt_reg - KCNT_W'(1);
          end
        end
      end
      default: begin
        state_next = RUN;
        kcnt_next  = '0;
      end
    endcase
  end

  always_comb begin
    PCsrc = PCSRC_SEQ;
    stall = 1'b0;
    kill  = 1'b0;
    if (!rst_n) begin
      PCsrc = PCSRC_SEQ;
    end else if (ext_stall) begin
      stall = 1'b1;
    end else if (state_reg == KILL) begin
      kill = 1'b1;
    end else if (load_use) begin
      stall = 1'b1;
    end else if (ret_req) begin
      PCsrc = PCSRC_RET;
      kill  = 1'b1;
    end else if (jump_req || call_req) begin
      PCsrc = PCSRC_JMP;
      kill  = 1'b1;
    end else if (branch_taken) begin
      PCsrc = PCSRC_BR;
      kill  = 1'b1;
    end
  end

  return_addr_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept & call_req),
    .pop      (accept & ret_req),
    .link_addr(link_addr),
    .top      (ReturnAddress),
    .err      (ras_err)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_reg, kill_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      kill_cnt_reg  <= '0;
    end else begin
      if (stall && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (kill && kill_cnt_reg != '1)   kill_cnt_reg  <= kill_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign kill_cnt  = kill_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (KILL_CYCLES 1 and 3) on shared
// inputs, checked each cycle against a behavioural stack/squash model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ext_stall = 1'b0, load_use = 1'b0, jump_req = 1'b0;
  logic        branch_taken = 1'b0, call_req = 1'b0, ret_req = 1'b0;
  logic [15:0] link_addr = '0;

  logic [1:0]  pc0, pc1;
  logic        st0, st1, k0, k1, e0, e1;
  logic [15:0] ra0, ra1;

  int vectors = 0;
  int miscompares = 0;

  // Model: stack as an ordered list (index 0 = oldest), squash cycles left.
  logic [15:0] mstk [2][4];
  int          msz [2];
  int          mkill [2];
  logic        merr [2];

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(16), .RAS_DEPTH(4), .KILL_CYCLES(1)) dut_k1 (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .load_use(load_use),
    .jump_req(jump_req), .branch_taken(branch_taken), .call_req(call_req),
    .ret_req(ret_req), .link_addr(link_addr), .PCsrc(pc0), .stall(st0),
    .kill(k0), .ReturnAddress(ra0), .ras_err(e0)
  );

  fetch_sequencer #(.ADDR_W(16), .RAS_DEPTH(4), .KILL_CYCLES(3)) dut_k3 (
    .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .load_use(load_use),
    .jump_req(jump_req), .branch_taken(branch_taken), .call_req(call_req),
    .ret_req(ret_req), .link_addr(link_addr), .PCsrc(pc1), .stall(st1),
    .kill(k1), .ReturnAddress(ra1), .ras_err(e1)
  );

  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[k%0d] observed=%0h expected=%0h", tag, (idx == 0) ? 1 : 3, obs, exp);
    end
  endtask

  task automatic check_outputs(input int i, input logic [1:0] epc, input logic est,
                               input logic ek, input logic [15:0] era, input logic eerr);
    logic [1:0]  opc;
    logic        ost, ok, oerr;
    logic [15:0] ora;
    opc  = (i == 0) ? pc0 : pc1;
    ost  = (i == 0) ? st0 : st1;
    ok   = (i == 0) ? k0  : k1;
    ora  = (i == 0) ? ra0 : ra1;
    oerr = (i == 0) ? e0  : e1;
    chk("PCsrc", i, {30'd0, opc}, {30'd0, epc});
    chk("stall", i, {31'd0, ost}, {31'd0, est});
    chk("kill", i, {31'd0, ok}, {31'd0, ek});
    chk("ReturnAddress", i, {16'd0, ora}, {16'd0, era});
    chk("ras_err", i, {31'd0, oerr}, {31'd0, eerr});
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      msz[i]   = 0;
      mkill[i] = 0;
      merr[i]  = 1'b0;
      for (int j = 0; j < 4; j++) mstk[i][j] = '0;
    end
  endtask

  task automatic clear_inputs();
    ext_stall = 0; load_use = 0; jump_req = 0; branch_taken = 0;
    call_req = 0; ret_req = 0; link_addr = '0;
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, advance model.
  task automatic step(input logic e, input logic l, input logic j, input logic b,
                      input logic c, input logic r, input logic [15:0] la);
    logic [1:0]  epc;
    logic        est, ek;
    logic [15:0] etop;
    int          act [2];
    logic        acc [2];
    ext_stall = e; load_use = l; jump_req = j; branch_taken = b;
    call_req = c; ret_req = r; link_addr = la;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      epc = 2'b00; est = 0; ek = 0; act[i] = 0; acc[i] = 0;
      etop = (msz[i] > 0) ? mstk[i][msz[i]-1] : 16'h0000;
      if (e) est = 1;
      else if (mkill[i] > 0) ek = 1;
      else if (l) est = 1;
      else if (r) begin epc = 2'b11; ek = 1; act[i] = c ? 3 : 2; acc[i] = 1; end
      else if (j || c) begin epc = 2'b01; ek = 1; act[i] = c ? 1 : 0; acc[i] = 1; end
      else if (b) begin epc = 2'b10; ek = 1; acc[i] = 1; end
      check_outputs(i, epc, est, ek, etop, merr[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!e && mkill[i] > 0) mkill[i]--;
      else if (acc[i]) mkill[i] = (i == 0) ? 0 : 2;
      if (act[i] == 1) begin
        if (msz[i] == 4) begin
          for (int k = 0; k < 3; k++) mstk[i][k] = mstk[i][k+1];
          mstk[i][3] = la;
          merr[i] = 1;
        end else begin
          mstk[i][msz[i]] = la;
          msz[i]++;
        end
      end else if (act[i] >= 2) begin
        if (act[i] == 3) merr[i] = 1;
        if (msz[i] == 0) merr[i] = 1;
        else msz[i]--;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 16'h0000);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic mid_reset();
    rst_n = 0;
    jump_req = 1; call_req = 1; link_addr = 16'hBEEF;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #1;
    rst_n = 0;
    jump_req = 1; ret_req = 1;
    #2;
    for (int i = 0; i < 2; i++) check_outputs(i, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1;
    clear_inputs();
    @(posedge clk);
    #1;

    // Underflow from reset, then call/return, then a late-cycle branch and reset.
    step(0, 0, 0, 0, 0, 1, 16'h0000);
    idle(3);
    step(0, 0, 0, 0, 1, 0, 16'h0011);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 16'h0000);
    idle(3);
    step(0, 0, 0, 0, 0, 1, 16'h0000);
    idle(3);
    step(0, 0, 0, 0, 1, 0, 16'h0022);
    idle(3);
    step(0, 0, 0, 1, 0, 0, 16'h0000);
    mid_reset();

    // Priority ordering.
    step(1, 0, 0, 1, 0, 0, 16'h0000);
    step(0, 1, 1, 0, 0, 0, 16'h0000);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    idle(3);

    // Squash window with ignored returns and a stall inside it.
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 0, 1, 16'h0000);
    step(1, 0, 0, 0, 0, 1, 16'h0000);
    step(0, 0, 0, 0, 0, 1, 16'h0000);
    step(0, 0, 0, 0, 0, 1, 16'h0000);
    idle(3);

    // Overflow: five pushes into four entries, then four pops.
    mid_reset();
    for (int v = 1; v <= 5; v++) begin
      step(0, 0, 0, 0, 1, 0, 16'(v));
      idle(3);
    end
    for (int v = 0; v < 4; v++) begin
      step(0, 0, 0, 0, 0, 1, 16'h0000);
      idle(3);
    end

    // Simultaneous call and return.
    mid_reset();
    step(0, 0, 0, 0, 1, 1, 16'h1234);
    idle(3);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
             16'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
